// File: rtl/somador_arbiter_if.sv
// Handshake and data bundle between two operand requesters, the shared adder and
// its result consumer. The slave modport is the adder's view; master is the environment's.
interface somador_arbiter_if #(
  parameter int NUM_BITS = 8
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic signed [NUM_BITS-1:0] a0;
  logic signed [NUM_BITS-1:0] b0;
  logic signed [NUM_BITS-1:0] a1;
  logic signed [NUM_BITS-1:0] b1;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_id;
  logic signed [NUM_BITS-1:0] S;
  logic                       Z;
  logic                       N;
  logic                       P;

  modport master (
    output req_valid, a0, b0, a1, b1, out_ready,
    input  req_ready, out_valid, out_id, S, Z, N, P
  );

  modport slave (
    input  req_valid, a0, b0, a1, b1, out_ready,
    output req_ready, out_valid, out_id, S, Z, N, P
  );
endinterface

// File: rtl/somador_arbiter.sv
// Round-robin shared signed adder with a single registered result stage.
// Define SOMADOR_SAT_EN to clamp signed overflow instead of wrapping.
module somador_arbiter #(
  parameter int NUM_BITS = 8
) (
  input logic              clock,
  input logic              reset_n,
  somador_arbiter_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                     state;
  state_t                     next_state;
  logic                       prio;
  logic                       g;
  logic [1:0]                 grant;
  logic [1:0]                 ready;
  logic                       free;
  logic                       accept;
  logic signed [NUM_BITS-1:0] a_g;
  logic signed [NUM_BITS-1:0] b_g;
  logic signed [NUM_BITS-1:0] raw_sum;
  logic signed [NUM_BITS-1:0] sum_next;
  logic signed [NUM_BITS-1:0] s_reg;
  logic                       id_reg;

  // Arbitration, stage-free test and output-stage next state; ready is
  // forced low while reset is held so nothing is taken during reset.
  always_comb begin
    grant      = 2'b00;
    g          = prio;
    next_state = state;
    case (bus.req_valid)
      2'b01: begin
        grant = 2'b01;
        g     = 1'b0;
      end
      2'b10: begin
        grant = 2'b10;
        g     = 1'b1;
      end
      2'b11: begin
        grant = prio ? 2'b10 : 2'b01;
        g     = prio;
      end
      default: begin
        grant = 2'b00;
        g     = prio;
      end
    endcase
    free   = (state == EMPTY) || bus.out_ready;
    ready  = (reset_n && free) ? grant : 2'b00;
    accept = |(bus.req_valid & ready);
    if (accept) begin
      next_state = FULL;
    end else if ((state == FULL) && bus.out_ready) begin
      next_state = EMPTY;
    end
  end

  assign a_g     = g ? bus.a1 : bus.a0;
  assign b_g     = g ? bus.b1 : bus.b0;
  assign raw_sum = a_g + b_g;

`ifdef SOMADOR_SAT_EN
  logic overflow;

  // Overflow is only possible when both operands share a sign the sum lost.
  always_comb begin
    overflow = (a_g[NUM_BITS-1] == b_g[NUM_BITS-1]) &&
               (raw_sum[NUM_BITS-1] != a_g[NUM_BITS-1]);
    sum_next = raw_sum;
    if (overflow) begin
      sum_next = a_g[NUM_BITS-1] ? {1'b1, {(NUM_BITS-1){1'b0}}}
                                 : {1'b0, {(NUM_BITS-1){1'b1}}};
    end
  end
`else
  assign sum_next = raw_sum;
`endif

  // Result register, winner id and round-robin pointer (loser preferred next).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      prio   <= 1'b0;
      s_reg  <= '0;
      id_reg <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        s_reg  <= sum_next;
        id_reg <= g;
        prio   <= ~g;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = (state == FULL);
  assign bus.out_id    = id_reg;
  assign bus.S         = s_reg;
  assign bus.Z         = (s_reg == '0);
  assign bus.N         = s_reg[NUM_BITS-1];
  assign bus.P         = ~s_reg[0];

endmodule

// File: tb/tb_somador_arbiter.sv
// Scoreboard bench for somador_arbiter: directed cases followed by random traffic,
// checked against a queue-based arithmetic model of arbitration and the result stage.
module tb_somador_arbiter;

  localparam int NB = 8;

  typedef struct {
    logic signed [NB-1:0] s;
    logic                 id;
  } res_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  int   assert_count = 0;
  int   fail_count   = 0;
  res_t sb[$];
  res_t staged;
  bit   staged_valid = 1'b0;
  int   prio_m       = 0;
  int   wait_cnt[2]  = '{0, 0};
  int   grants[2]    = '{0, 0};

  somador_arbiter_if #(.NUM_BITS(NB)) bus ();

  somador_arbiter #(.NUM_BITS(NB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    forever #10 clock = ~clock;
  end

  // Reference sum: exact integer add, then clamp or wrap into NB bits.
  function automatic logic signed [NB-1:0] model_sum(int x, int y);
    int lo;
    int hi;
    int t;
    lo = -(2 ** (NB - 1));
    hi = (2 ** (NB - 1)) - 1;
    t  = x + y;
`ifdef SOMADOR_SAT_EN
    if (t > hi) t = hi;
    if (t < lo) t = lo;
`else
    t = (t - lo) % (2 ** NB);
    if (t < 0) t = t + (2 ** NB);
    t = t + lo;
    if (t > hi) t = hi;
`endif
    return t[NB-1:0];
  endfunction

  task automatic compare_result(string name, res_t e, logic ez, logic en, logic ep);
    assert_count++;
    if (bus.out_valid !== 1'b1 || bus.S !== e.s || bus.out_id !== e.id ||
        bus.Z !== ez || bus.N !== en || bus.P !== ep) begin
      fail_count++;
      $display("[TB] FAIL %s: got valid=%0b S=%0d id=%0b Z=%0b N=%0b P=%0b, expected valid=1 S=%0d id=%0b Z=%0b N=%0b P=%0b",
               name, bus.out_valid, bus.S, bus.out_id, bus.Z, bus.N, bus.P,
               e.s, e.id, ez, en, ep);
    end
  endtask

  task automatic checkReset(string name);
    assert_count++;
    if (bus.out_valid !== 1'b0 || bus.S !== '0 || bus.Z !== 1'b1 || bus.N !== 1'b0 ||
        bus.P !== 1'b1 || bus.out_id !== 1'b0 || bus.req_ready !== 2'b00) begin
      fail_count++;
      $display("[TB] FAIL %s: got valid=%0b S=%0d Z=%0b N=%0b P=%0b id=%0b req_ready=%b, expected 0 0 1 0 1 0 00",
               name, bus.out_valid, bus.S, bus.Z, bus.N, bus.P, bus.out_id, bus.req_ready);
    end
  endtask

  // Drives one cycle of inputs, predicts which requester is taken and stages its result.
  task automatic applyStimulus(input logic [1:0] v, input int x0, input int y0,
                               input int x1, input int y1, input bit rdy,
                               output logic [1:0] acc, output logic [1:0] seen);
    int         gid;
    bit         free;
    logic [1:0] exp_ready;
    @(negedge clock);
    #2;
    bus.req_valid = v;
    bus.a0        = x0[NB-1:0];
    bus.b0        = y0[NB-1:0];
    bus.a1        = x1[NB-1:0];
    bus.b1        = y1[NB-1:0];
    bus.out_ready = rdy;
    #1;
    free = (sb.size() == 0) || rdy;
    if (v == 2'b00)      gid = -1;
    else if (v == 2'b01) gid = 0;
    else if (v == 2'b10) gid = 1;
    else                 gid = prio_m;
    exp_ready = 2'b00;
    if (free && gid == 0) exp_ready = 2'b01;
    if (free && gid == 1) exp_ready = 2'b10;
    seen = bus.req_ready;
    acc  = exp_ready;
    assert_count++;
    if (seen !== exp_ready) begin
      fail_count++;
      $display("[TB] FAIL req_ready: got %b, expected %b (valid=%b out_ready=%0b)",
               seen, exp_ready, v, rdy);
    end
    if (exp_ready != 2'b00) begin
      staged.s     = (gid == 0) ? model_sum(int'($signed(bus.a0)), int'($signed(bus.b0)))
                                : model_sum(int'($signed(bus.a1)), int'($signed(bus.b1)));
      staged.id    = (gid == 1);
      staged_valid = 1'b1;
      prio_m       = 1 - gid;
    end
    for (int i = 0; i < 2; i++) begin
      if (v[i] && !seen[i] && seen[1-i]) begin
        wait_cnt[i]++;
        assert_count++;
        if (wait_cnt[i] > 1) begin
          fail_count++;
          $display("[TB] FAIL starvation: requester %0d passed over %0d times, expected at most 1",
                   i, wait_cnt[i]);
        end
      end else if (!v[i] || seen[i]) begin
        wait_cnt[i] = 0;
      end
    end
  endtask

  task automatic checkOutput(string name, int es, logic ez, logic en, logic ep, logic eid);
    res_t e;
    @(posedge clock);
    #1;
    e.s  = es[NB-1:0];
    e.id = eid;
    compare_result(name, e, ez, en, ep);
  endtask

  // A staged result becomes visible at the edge that accepts it.
  initial begin
    forever begin
      @(posedge clock);
      if (staged_valid) begin
        if (reset_n) sb.push_back(staged);
        staged_valid = 1'b0;
      end
    end
  end

  // Monitor: just before each edge, the output must match the oldest expected result.
  initial begin
    logic ez;
    logic en;
    logic ep;
    forever begin
      @(negedge clock);
      #8;
      if (reset_n) begin
        assert_count++;
        if (bus.out_valid !== (sb.size() > 0)) begin
          fail_count++;
          $display("[TB] FAIL out_valid: got %0b, expected %0b (pending=%0d)",
                   bus.out_valid, (sb.size() > 0), sb.size());
        end
        if (bus.out_valid === 1'b1 && sb.size() > 0) begin
          ez = (sb[0].s == 0);
          en = (sb[0].s < 0);
          ep = ((int'(sb[0].s) % 2) == 0);
          compare_result("scoreboard", sb[0], ez, en, ep);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [1:0] acc;
    logic [1:0] seen;
    logic [1:0] v;
    int         ra[2];
    int         rb[2];
    bit         rdy;

    bus.req_valid = 2'b00;
    bus.a0        = '0;
    bus.b0        = '0;
    bus.a1        = '0;
    bus.b1        = '0;
    bus.out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #4 checkReset("power-on reset");
    @(negedge clock);
    #3 reset_n = 1'b1;

    // Single requester, zero result.
    applyStimulus(2'b01, 5, -5, 0, 0, 1'b1, acc, seen);
    checkOutput("single 5+(-5)", 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Mid-stream reset with a result pending and both requesters waiting.
    applyStimulus(2'b11, 5, 3, 4, -7, 1'b1, acc, seen);
    applyStimulus(2'b11, 5, 3, 4, -7, 1'b0, acc, seen);
    #1;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    #1 checkReset("mid-stream reset");
    sb.delete();
    staged_valid = 1'b0;
    prio_m       = 0;
    wait_cnt     = '{0, 0};
    @(posedge clock);
    #1 checkReset("reset held over edge");
    @(negedge clock);
    bus.req_valid = 2'b00;
    #3 reset_n = 1'b1;

    // Both requesters streaming: grants alternate from requester 0.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 5, 3, 4, -7, 1'b1, acc, seen);
      assert_count++;
      if (seen !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        fail_count++;
        $display("[TB] FAIL alternate grant %0d: got %b, expected %b",
                 k, seen, ((k % 2 == 0) ? 2'b01 : 2'b10));
      end
      if (k % 2 == 0) checkOutput("sum 5+3", 8, 1'b0, 1'b0, 1'b1, 1'b0);
      else            checkOutput("sum 4+(-7)", -3, 1'b0, 1'b1, 1'b0, 1'b1);
    end

    // Backpressure: result held, nothing accepted, then resumes in the same cycle.
    applyStimulus(2'b01, 10, 20, 0, 0, 1'b1, acc, seen);
    checkOutput("load 10+20", 30, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 1, 2, 3, 4, 1'b0, acc, seen);
      assert_count++;
      if (seen !== 2'b00) begin
        fail_count++;
        $display("[TB] FAIL backpressure ready %0d: got %b, expected 00", k, seen);
      end
      checkOutput("backpressure hold", 30, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(2'b11, 1, 2, 3, 4, 1'b1, acc, seen);
    assert_count++;
    if (seen !== 2'b10) begin
      fail_count++;
      $display("[TB] FAIL backpressure release: got %b, expected 10", seen);
    end
    checkOutput("release 3+4", 7, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b01, 1, 2, 3, 4, 1'b1, acc, seen);
    checkOutput("waiting 1+2", 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Signed overflow in both directions.
    applyStimulus(2'b01, 100, 100, 0, 0, 1'b1, acc, seen);
`ifdef SOMADOR_SAT_EN
    checkOutput("sat 100+100", 127, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    checkOutput("wrap 100+100", -56, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
    applyStimulus(2'b10, 0, 0, -100, -100, 1'b1, acc, seen);
`ifdef SOMADOR_SAT_EN
    checkOutput("sat -100-100", -128, 1'b0, 1'b1, 1'b1, 1'b1);
`else
    checkOutput("wrap -100-100", 56, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, acc, seen);

    // Random traffic; a requester keeps its operands until taken.
    v   = 2'b00;
    acc = 2'b00;
    ra  = '{0, 0};
    rb  = '{0, 0};
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(v[i] && !acc[i])) begin
          v[i]  = ($urandom_range(0, 99) < 60);
          ra[i] = int'($urandom_range(0, 255)) - 128;
          rb[i] = int'($urandom_range(0, 255)) - 128;
        end
      end
      rdy = ($urandom_range(0, 99) < 70);
      applyStimulus(v, ra[0], rb[0], ra[1], rb[1], rdy, acc, seen);
      grants[0] += int'(seen[0]);
      grants[1] += int'(seen[1]);
    end
    repeat (3) applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, acc, seen);
    #6;
    assert_count++;
    if (sb.size() != 0 || staged_valid) begin
      fail_count++;
      $display("[TB] FAIL drain: got %0d results outstanding, expected 0", sb.size());
    end
    $display("[TB] random grants: requester0=%0d requester1=%0d", grants[0], grants[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
